// File: rtl/mem_access_unit.sv
// Load/store unit: turns a core byte/word request into one single-beat memory bus access.
// Optional bus timeout abort is enabled with macro LSU_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       lat_word;
  logic [1:0] lat_off;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`endif

  assign req_ready = (state == IDLE);

  // Word loads pass through; byte loads pick the addressed lane and sign-extend.
  function automatic logic [31:0] load_ext(input logic word, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0] b;
    if (word) return d;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return {{24{b[7]}}, b};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bus_stb    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= '0;
      bus_adr    <= '0;
      bus_dat_o  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata      <= '0;
      lat_word   <= 1'b0;
      lat_off    <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_word <= mem_size;
            lat_off  <= addr[1:0];
            if (!mem_read && !mem_write) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              rdata      <= '0;
            end else if (mem_size && (addr[1:0] != 2'b00)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              rdata      <= '0;
            end else begin
              // Store wins when both flags are set.
              state     <= BUS;
              bus_stb   <= 1'b1;
              bus_we    <= mem_write;
              bus_adr   <= {addr[31:2], 2'b00};
              bus_sel   <= mem_size ? 4'hF : (4'b0001 << addr[1:0]);
              bus_dat_o <= !mem_write ? '0 : (mem_size ? wdata : {4{wdata[7:0]}});
`ifdef LSU_TIMEOUT_EN
              cnt       <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_stb    <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            rdata      <= bus_we ? '0 : load_ext(lat_word, lat_off, bus_dat_i);
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            bus_stb    <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            rdata      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single transactions plus
// reset-abort and bus-wait/timeout sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic        mem_read, mem_write, mem_size;
  logic [31:0] addr, wdata;
  logic        resp_valid, resp_err;
  logic [31:0] rdata;
  logic        bus_stb, bus_we, bus_ack;
  logic [3:0]  bus_sel;
  logic [31:0] bus_adr, bus_dat_o, bus_dat_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .resp_err(resp_err),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel), .bus_adr(bus_adr),
    .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        rd, wr, sz;
    logic [31:0] a, wd, din;
    int unsigned delay;
    logic        usebus, we;
    logic [3:0]  sel;
    logic [31:0] adr, dato, rdat;
    logic        err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic sz,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; addr = a; wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //            rd  wr  sz  addr          wdata         din           dly bus we  sel     adr           dato          rdata         err
    vecs[0] = '{1'b1,1'b0,1'b1,32'h0000_0100,32'h0,        32'hDEAD_BEEF,0, 1'b1,1'b0,4'hF,  32'h0000_0100,32'h0,        32'hDEAD_BEEF,1'b0};
    vecs[1] = '{1'b1,1'b0,1'b0,32'h0000_0203,32'h0,        32'h8011_2233,0, 1'b1,1'b0,4'b1000,32'h0000_0200,32'h0,       32'hFFFF_FF80,1'b0};
    vecs[2] = '{1'b0,1'b1,1'b0,32'h0000_0301,32'h0000_00A5,32'h1111_1111,0, 1'b1,1'b1,4'b0010,32'h0000_0300,32'hA5A5_A5A5,32'h0,        1'b0};
    vecs[3] = '{1'b1,1'b0,1'b1,32'h0000_0102,32'h0,        32'h0,        0, 1'b0,1'b0,4'h0,  32'h0,        32'h0,        32'h0,        1'b1};
    vecs[4] = '{1'b1,1'b1,1'b1,32'h0000_0400,32'h1234_5678,32'hFFFF_FFFF,1, 1'b1,1'b1,4'hF,  32'h0000_0400,32'h1234_5678,32'h0,        1'b0};
    vecs[5] = '{1'b1,1'b0,1'b0,32'h0000_0001,32'h0,        32'h0000_7F00,2, 1'b1,1'b0,4'b0010,32'h0000_0000,32'h0,       32'h0000_007F,1'b0};
    vecs[6] = '{1'b0,1'b0,1'b1,32'h0000_0800,32'hFFFF_FFFF,32'h0,        0, 1'b0,1'b0,4'h0,  32'h0,        32'h0,        32'h0,        1'b0};
    vecs[7] = '{1'b0,1'b1,1'b1,32'h0000_0503,32'hCAFE_F00D,32'h0,        0, 1'b0,1'b0,4'h0,  32'h0,        32'h0,        32'h0,        1'b1};
    vecs[8] = '{1'b1,1'b0,1'b0,32'h0000_0502,32'h0,        32'h00AB_0000,0, 1'b1,1'b0,4'b0100,32'h0000_0500,32'h0,       32'hFFFF_FFAB,1'b0};
    vecs[9] = '{1'b0,1'b1,1'b0,32'h0000_0600,32'hFFFF_FF3C,32'h0,        3, 1'b1,1'b1,4'b0001,32'h0000_0600,32'h3C3C_3C3C,32'h0,       1'b0};

    reset = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 1'b0;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_dat_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_stb",   32'(bus_stb), 32'd0);
    chk("rst_we",    32'(bus_we), 32'd0);
    chk("rst_sel",   32'(bus_sel), 32'd0);
    chk("rst_adr",   bus_adr, 32'd0);
    chk("rst_dato",  bus_dat_o, 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err",   32'(resp_err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      chk($sformatf("v%0d_ready_idle", i), 32'(req_ready), 32'd1);
      issue(v.rd, v.wr, v.sz, v.a, v.wd);
      @(negedge clk);  // cycle 1
      req_valid = 1'b0;
      chk($sformatf("v%0d_ready_busy", i), 32'(req_ready), 32'd0);
      if (v.usebus) begin
        chk($sformatf("v%0d_stb", i), 32'(bus_stb), 32'd1);
        chk($sformatf("v%0d_we", i),  32'(bus_we), 32'(v.we));
        chk($sformatf("v%0d_sel", i), 32'(bus_sel), 32'(v.sel));
        chk($sformatf("v%0d_adr", i), bus_adr, v.adr);
        if (v.we) chk($sformatf("v%0d_dato", i), bus_dat_o, v.dato);
        chk($sformatf("v%0d_early_valid", i), 32'(resp_valid), 32'd0);
        for (int k = 0; k < int'(v.delay); k++) begin
          @(negedge clk);
          chk($sformatf("v%0d_wait%0d_stb", i, k), 32'(bus_stb), 32'd1);
          chk($sformatf("v%0d_wait%0d_adr", i, k), bus_adr, v.adr);
          chk($sformatf("v%0d_wait%0d_sel", i, k), 32'(bus_sel), 32'(v.sel));
        end
        bus_dat_i = v.din; bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0; bus_dat_i = '0;
        chk($sformatf("v%0d_stb_drop", i), 32'(bus_stb), 32'd0);
      end else begin
        chk($sformatf("v%0d_nobus_stb", i), 32'(bus_stb), 32'd0);
      end
      chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d_rdata", i), rdata, v.rdat);
      chk($sformatf("v%0d_err", i), 32'(resp_err), 32'(v.err));
      @(negedge clk);
      chk($sformatf("v%0d_valid_1cyc", i), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d_rdata_hold", i), rdata, v.rdat);
      chk($sformatf("v%0d_err_hold", i), 32'(resp_err), 32'(v.err));
    end

    // Reset in the middle of a bus access, then a late ack.
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0900, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_stb_before", 32'(bus_stb), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rstmid_stb_after", 32'(bus_stb), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_adr", bus_adr, 32'd0);
    bus_dat_i = 32'h5555_5555; bus_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      chk($sformatf("rstmid_novalid%0d", k), 32'(resp_valid), 32'd0);
      chk($sformatf("rstmid_nostb%0d", k), 32'(bus_stb), 32'd0);
      chk($sformatf("rstmid_ready%0d", k), 32'(req_ready), 32'd1);
    end
    chk("rstmid_rdata", rdata, 32'd0);
    bus_dat_i = '0;

    // Load that never gets acked.
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0700, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_stb_c%0d", k), 32'(bus_stb), 32'd1);
      chk($sformatf("to_novalid_c%0d", k), 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("to_stb_drop", 32'(bus_stb), 32'd0);
    chk("to_valid", 32'(resp_valid), 32'd1);
    chk("to_err", 32'(resp_err), 32'd1);
    chk("to_rdata", rdata, 32'd0);
    @(negedge clk);
    chk("to_valid_1cyc", 32'(resp_valid), 32'd0);
    chk("to_ready", 32'(req_ready), 32'd1);
`else
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("wait_stb_c%0d", k), 32'(bus_stb), 32'd1);
      chk($sformatf("wait_novalid_c%0d", k), 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    bus_dat_i = 32'h0102_0304; bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("wait_stb_drop", 32'(bus_stb), 32'd0);
    chk("wait_valid", 32'(resp_valid), 32'd1);
    chk("wait_rdata", rdata, 32'h0102_0304);
    chk("wait_err", 32'(resp_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max bus wait cycles before abort (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  core request present.
REQ-005 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: mem_read  input  1  load request (the decoder's MemRead).
REQ-007 SHALL have port: mem_write  input  1  store request (the decoder's MemWrite).
REQ-008 SHALL have port: mem_size  input  1  1 = 32-bit word, 0 = 8-bit byte (the decoder's MemSize).
REQ-009 SHALL have port: addr  input  32  byte address from ALU.
REQ-010 SHALL have port: wdata  input  32  store data.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port: rdata  output  32  load result, valid with resp_valid.
REQ-013 SHALL have port: resp_err  output  1  error flag, valid with resp_valid.
REQ-014 SHALL have ports: bus_stb output 1, bus_we output 1, bus_sel output 4, bus_adr output 32, bus_dat_o output 32, bus_dat_i input 32, bus_ack input 1 (single-beat memory bus).

Function
REQ-015 SHALL implement FSM states IDLE, BUS, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with req_valid & req_ready, latching mem_read, mem_write, mem_size, addr, wdata.
REQ-017 SHALL treat mem_write as priority when mem_read and mem_write are both set (store).
REQ-018 SHALL, for an accepted request with neither flag set, go IDLE->RESP with no bus access, rdata = 0, resp_err = 0.
REQ-019 SHALL, for a word request with addr[1:0] != 0, go IDLE->RESP with no bus access, resp_err = 1, rdata = 0.
REQ-020 SHALL otherwise go IDLE->BUS; all bus outputs registered; bus_stb = 1 from the cycle after acceptance until bus_ack is sampled high.
REQ-021 SHALL drive bus_adr = {addr[31:2], 2'b00}; bus_we = 1 for stores, 0 for loads.
REQ-022 SHALL drive bus_sel = 4'hF for words and 4'b0001 << addr[1:0] for bytes.
REQ-023 SHALL drive bus_dat_o = wdata for word stores and {4{wdata[7:0]}} for byte stores.
REQ-024 SHALL, on bus_ack in BUS, deassert bus_stb next cycle, capture the load data, and enter RESP.
REQ-025 SHALL return the word load as bus_dat_i; byte load as sign-extended bus_dat_i[8*addr[1:0] +: 8]; stores return rdata = 0.
REQ-026 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; rdata/resp_err SHALL hold until the next response.
REQ-027 SHALL have minimum latency: acceptance at cycle 0, bus_stb at cycle 1, ack sampled at cycle 1, resp_valid at cycle 2.
REQ-028 SHALL ignore bus_ack outside BUS.
REQ-029 SHALL hold bus_adr, bus_sel, bus_we, bus_dat_o stable while bus_stb = 1.

Reset
REQ-030 SHALL, when reset is low at a clock edge, enter IDLE and clear bus_stb, bus_we, bus_sel, bus_adr, bus_dat_o, resp_valid, resp_err, rdata to 0, and clear the timeout counter.
REQ-031 SHALL, on reset mid-transaction, drop bus_stb the next cycle, produce no resp_valid, and ignore any late bus_ack.

Configuration
REQ-032 SHALL, with macro LSU_TIMEOUT_EN defined, count cycles in BUS; if TIMEOUT_CYCLES cycles elapse without bus_ack, SHALL drop bus_stb, enter RESP with resp_err = 1, rdata = 0; without the macro SHALL wait in BUS indefinitely and SHALL contain no counter logic.

Verification
REQ-033 SHALL test: word load addr=0x100, bus_dat_i=0xDEADBEEF, ack at cycle 1 -> bus_sel=F, bus_adr=0x100, resp_valid at cycle 2, rdata=0xDEADBEEF, resp_err=0.
REQ-034 SHALL test: byte load addr=0x203, bus_dat_i=0x80112233 -> bus_sel=4'b1000, bus_adr=0x200, rdata=0xFFFFFF80.
REQ-035 SHALL test: byte store addr=0x301, wdata=0x000000A5 -> bus_we=1, bus_sel=4'b0010, bus_dat_o=0xA5A5A5A5.
REQ-036 SHALL test: word load addr=0x102 -> no bus_stb, resp_valid at cycle 1, resp_err=1.
REQ-037 SHALL test: reset low while bus_stb=1, then ack -> bus_stb=0 after reset, no resp_valid, req_ready=1.
REQ-038 SHALL test (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4): load with no ack -> bus_stb drops after 4 cycles, resp_valid with resp_err=1.
